// File: rtl/vga_capture_if.sv
// Incoming VGA-style stream: active-low syncs plus 12-bit colour.
// The source drives it (master); the capture block samples it (slave).
interface vga_capture_if;
    logic       Hsync;
    logic       Vsync;
    logic [3:0] vgaRed;
    logic [3:0] vgaBlue;
    logic [3:0] vgaGreen;

    modport master (output Hsync, Vsync, vgaRed, vgaBlue, vgaGreen);
    modport slave  (input  Hsync, Vsync, vgaRed, vgaBlue, vgaGreen);
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: recovers x/y from the sync edges, verifies line/frame timing,
// and once locked emits one write strobe per active pixel with its coordinate and colour.
module vga_capture #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BACK      = 48,
    parameter int unsigned H_DISP      = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BACK      = 33,
    parameter int unsigned V_DISP      = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic         clk,
    input  logic         rst,
    vga_capture_if.slave vga,
    output logic         cap_we,
    output logic [10:0]  cap_xpos,
    output logic [10:0]  cap_ypos,
    output logic [11:0]  cap_data,
    output logic         frame_start,
    output logic         locked,
    output logic [10:0]  h_meas,
    output logic [10:0]  v_meas
);
    localparam logic [10:0] H_START = 11'(H_SYNC + H_BACK);
    localparam logic [10:0] H_END   = 11'(H_SYNC + H_BACK + H_DISP);
    localparam logic [10:0] V_START = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_END   = 11'(V_SYNC + V_BACK + V_DISP);
    localparam logic [11:0] H_LEN   = 12'(H_TOTAL);
    localparam logic [11:0] V_LEN   = 12'(V_TOTAL);
    localparam logic [10:0] H_LOST  = 11'(2 * H_TOTAL - 1);
    localparam logic [10:0] V_LOST  = 11'(2 * V_TOTAL - 1);
    localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
    localparam logic [10:0] CNT_MAX = '1;

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} lock_state_t;

    lock_state_t state, state_next;
    logic [3:0]  good, good_next, good_inc;

    logic        hs_s1, vs_s1, hs_d, vs_fe;
    logic [11:0] rgb_s1;
    logic [10:0] hc_q, vc_q, hc, vc;
    logic [11:0] h_len, v_len;
    logic        fe, fs, line_bad, frame_good, lost, active, wr;

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_s1  <= 1'b1;
            vs_s1  <= 1'b1;
            hs_d   <= 1'b1;
            rgb_s1 <= '0;
        end else begin
            hs_s1  <= vga.Hsync;
            vs_s1  <= vga.Vsync;
            hs_d   <= hs_s1;
            rgb_s1 <= {vga.vgaRed, vga.vgaBlue, vga.vgaGreen};
        end
    end

    // hc/vc are the positions of the pixel currently in stage 1, so they are
    // formed combinationally from the edge and registered as hc_q/vc_q.
    always_comb begin
        fe         = hs_d & ~hs_s1;
        fs         = fe & ~vs_s1 & vs_fe;
        h_len      = {1'b0, hc_q} + 12'd1;
        v_len      = {1'b0, vc_q} + 12'd1;
        hc         = fe ? '0 : ((hc_q == CNT_MAX) ? CNT_MAX : hc_q + 11'd1);
        vc         = vc_q;
        if (fe) begin
            vc = fs ? '0 : ((vc_q == CNT_MAX) ? CNT_MAX : vc_q + 11'd1);
        end
        line_bad   = fe && (h_len != H_LEN);
        frame_good = (v_len == V_LEN);
        lost       = (hc == H_LOST) || (vc == V_LOST);
        active     = (hc >= H_START) && (hc < H_END) && (vc >= V_START) && (vc < V_END);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q   <= '0;
            vc_q   <= '0;
            vs_fe  <= 1'b1;
            h_meas <= '0;
            v_meas <= '0;
        end else begin
            hc_q <= hc;
            vc_q <= vc;
            if (fe) begin
                vs_fe  <= vs_s1;
                h_meas <= h_len[11] ? CNT_MAX : h_len[10:0];
            end
            if (fs) begin
                v_meas <= v_len[11] ? CNT_MAX : v_len[10:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            good  <= '0;
        end else begin
            state <= state_next;
            good  <= good_next;
        end
    end

    always_comb begin
        state_next = state;
        good_next  = good;
        good_inc   = good + 4'd1;
        case (state)
            SEARCH: begin
                if (fs) begin
                    state_next = CHECK;
                    good_next  = '0;
                end
            end
            CHECK: begin
                if (line_bad) begin
                    state_next = SEARCH;
                end else if (fs) begin
                    if (frame_good) begin
                        good_next = good_inc;
                        if (good_inc == LOCK_N) state_next = LOCKED;
                    end else begin
                        good_next = '0;
                    end
                end
            end
            LOCKED: begin
                if (line_bad || (fs && !frame_good)) state_next = SEARCH;
            end
            default: state_next = SEARCH;
        endcase
        if (lost) state_next = SEARCH;
        // Outputs follow the next state so lock/unlock land with the triggering edge.
        wr = active && (state_next == LOCKED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_we      <= 1'b0;
            cap_xpos    <= '0;
            cap_ypos    <= '0;
            cap_data    <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            cap_we      <= wr;
            cap_xpos    <= hc - H_START;
            cap_ypos    <= vc - V_START;
            cap_data    <= wr ? rgb_s1 : '0;
            frame_start <= fs;
            locked      <= (state_next == LOCKED);
        end
    end
endmodule
